// File: rtl/cart_cfg_loader_if.sv
// AXI4-Lite bundle between the cart configuration loader (master) and the
// cart register slave. Signal names keep the AXI channel naming.
interface cart_cfg_loader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/cart_cfg_loader.sv
// Cart configuration loader: receives a 16-byte iNES header, validates it,
// derives the size masks and mapper configuration, and writes them to the
// cart register slave over AXI4-Lite. mapper_config is written last so the
// slave can treat it as the commit of a new configuration.
module cart_cfg_loader #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int C_TIMEOUT          = 255
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESETN,
    input  logic              start,
    input  logic [7:0]        hdr_tdata,
    input  logic              hdr_tvalid,
    output logic              hdr_tready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code,
    cart_cfg_loader_if.master m_axi
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_ADDR  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_MAGIC = 2'd1;
    localparam logic [1:0] E_SIZE  = 2'd2;
    localparam logic [1:0] E_BUS   = 2'd3;

    localparam int         TW       = $clog2(C_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(C_TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    hdr_q [0:8];
    logic [7:0]    hdr_d [0:8];
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    idx_q, idx_d;
    logic          awv_q, awv_d;
    logic          wv_q, wv_d;
    logic          awok_q, awok_d;
    logic          wok_q, wok_d;
    logic [1:0]    err_q, err_d;

    logic          aw_hs;
    logic          w_hs;
    logic [31:0]   prg_mask;
    logic [31:0]   chr_mask;
    logic [31:0]   prgram_mask;
    logic [31:0]   mapper_cfg;
    logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          unused_rd;

    // Propagate the highest set bit into every lower bit.
    function automatic logic [31:0] smear(input logic [31:0] x);
        logic [31:0] r;
        r = x;
        for (int unsigned i = 31; i > 0; i--) begin
            r[i-1] = r[i-1] | r[i];
        end
        return r;
    endfunction

    assign aw_hs = awv_q & m_axi.AWREADY;
    assign w_hs  = wv_q & m_axi.WREADY;

    // Size masks and mapper configuration derived from the captured header.
    always_comb begin
        prg_mask    = smear(({24'h0, hdr_q[4]} << 14) - 32'd1);
        chr_mask    = (hdr_q[5] == 8'h00) ? 32'h0000_1FFF
                                          : smear(({24'h0, hdr_q[5]} << 13) - 32'd1);
        prgram_mask = (hdr_q[8] == 8'h00) ? 32'h0000_1FFF
                                          : smear(({24'h0, hdr_q[8]} << 13) - 32'd1);
        mapper_cfg  = {16'h0000, hdr_q[7][7:4], hdr_q[6][7:4], 6'h00,
                       hdr_q[6][1], hdr_q[6][0]};
    end

    // Select address and data for the current write; idx_q is constant while
    // the valids are up, which keeps AWADDR/WDATA stable.
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        case (idx_q)
            2'd0: begin
                wr_addr = C_M_AXI_ADDR_WIDTH'(8'h04);
                wr_data = chr_mask;
            end
            2'd1: begin
                wr_addr = C_M_AXI_ADDR_WIDTH'(8'h08);
                wr_data = prg_mask;
            end
            2'd2: begin
                wr_addr = C_M_AXI_ADDR_WIDTH'(8'h0C);
                wr_data = prgram_mask;
            end
            default: begin
                wr_addr = C_M_AXI_ADDR_WIDTH'(8'h00);
                wr_data = mapper_cfg;
            end
        endcase
    end

    // Next-state logic for the load sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        tmo_d   = tmo_q;
        idx_d   = idx_q;
        awv_d   = awv_q;
        wv_d    = wv_q;
        awok_d  = awok_q;
        wok_d   = wok_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RECV;
                    cnt_d   = '0;
                    err_d   = E_NONE;
                end
            end
            S_RECV: begin
                if (hdr_tvalid) begin
                    if (cnt_q <= 4'd8) begin
                        hdr_d[cnt_q] = hdr_tdata;
                    end
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if ({hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3]} != 32'h4E45_531A) begin
                    state_d = S_ERR;
                    err_d   = E_MAGIC;
                end else if (hdr_q[4] == 8'h00) begin
                    state_d = S_ERR;
                    err_d   = E_SIZE;
                end else begin
                    state_d = S_ADDR;
                    idx_d   = 2'd0;
                    awv_d   = 1'b1;
                    wv_d    = 1'b1;
                    awok_d  = 1'b0;
                    wok_d   = 1'b0;
                    tmo_d   = '0;
                end
            end
            S_ADDR: begin
                if (aw_hs) begin
                    awv_d  = 1'b0;
                    awok_d = 1'b1;
                end
                if (w_hs) begin
                    wv_d  = 1'b0;
                    wok_d = 1'b1;
                end
                // Handshakes completing this cycle count immediately.
                if ((awok_q | aw_hs) && (wok_q | w_hs)) begin
                    state_d = S_RESP;
                    tmo_d   = '0;
                end else if (tmo_q >= TMO_LAST) begin
                    state_d = S_ERR;
                    err_d   = E_BUS;
                    awv_d   = 1'b0;
                    wv_d    = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RESP: begin
                if (m_axi.BVALID) begin
                    if (m_axi.BRESP != 2'b00) begin
                        state_d = S_ERR;
                        err_d   = E_BUS;
                    end else if (idx_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADDR;
                        idx_d   = idx_q + 2'd1;
                        awv_d   = 1'b1;
                        wv_d    = 1'b1;
                        awok_d  = 1'b0;
                        wok_d   = 1'b0;
                        tmo_d   = '0;
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    state_d = S_ERR;
                    err_d   = E_BUS;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset clears every output-driving register at once.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            idx_q   <= '0;
            awv_q   <= 1'b0;
            wv_q    <= 1'b0;
            awok_q  <= 1'b0;
            wok_q   <= 1'b0;
            err_q   <= E_NONE;
            for (int unsigned i = 0; i < 9; i++) begin
                hdr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            idx_q   <= idx_d;
            awv_q   <= awv_d;
            wv_q    <= wv_d;
            awok_q  <= awok_d;
            wok_q   <= wok_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < 9; i++) begin
                hdr_q[i] <= hdr_d[i];
            end
        end
    end

    assign hdr_tready = (state_q == S_RECV);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err_code   = err_q;

    assign m_axi.AWADDR  = wr_addr;
    assign m_axi.AWPROT  = 3'b000;
    assign m_axi.AWVALID = awv_q;
    assign m_axi.WDATA   = C_M_AXI_DATA_WIDTH'(wr_data);
    assign m_axi.WSTRB   = '1;
    assign m_axi.WVALID  = wv_q;
    assign m_axi.BREADY  = (state_q == S_RESP);
    assign m_axi.ARADDR  = '0;
    assign m_axi.ARPROT  = 3'b000;
    assign m_axi.ARVALID = 1'b0;
    assign m_axi.RREADY  = 1'b0;

    // Read channel and unused header bits are intentionally ignored.
    assign unused_rd = ^{m_axi.ARREADY, m_axi.RDATA, m_axi.RRESP, m_axi.RVALID,
                         hdr_q[6][3:2], hdr_q[7][3:0]};

endmodule
